// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(255,239) decoder front-end sequencer.
package rs_pkg;

  localparam int RS_BEATS    = 16;
  localparam int RS_SYM_W    = 8;
  localparam int RS_NSYND    = 16;
  localparam int RS_BEAT_W   = 128;
  localparam int RS_SYND_W   = RS_SYM_W * RS_NSYND;
  localparam int RS_SYND_TMO = 32;
  localparam int RS_KES_TMO  = 255;
  localparam int RS_CNT_W    = $clog2(RS_BEATS);
  localparam int RS_TMO_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_SYND,
    ST_EVAL,
    ST_SOLVE,
    ST_RESULT,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    RES_OK       = 2'b00,
    RES_KES_FAIL = 2'b01,
    RES_FRAMING  = 2'b10,
    RES_TIMEOUT  = 2'b11
  } res_code_e;

endpackage

// File: rtl/rs_frame_tracker.sv
// Counts accepted beats of a codeword and classifies the frame end as clean or malformed.
module rs_frame_tracker
  import rs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic xfer_i,
  input  logic last_i,
  output logic beat0_o,
  output logic frame_ok_o,
  output logic frame_err_o,
  output logic missing_last_o
);

  logic [RS_CNT_W-1:0] beat_cnt_q;
  logic                at_final;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      beat_cnt_q <= '0;
    end else if (xfer_i) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign at_final       = (beat_cnt_q == RS_CNT_W'(RS_BEATS - 1));
  assign beat0_o        = (beat_cnt_q == '0);
  assign frame_ok_o     = xfer_i & last_i & at_final;
  // A frame that runs past its final beat leaves trailing beats to be drained later.
  assign missing_last_o = xfer_i & ~last_i & at_final;
  assign frame_err_o    = (xfer_i & last_i & ~at_final) | missing_last_o;

endmodule

// File: rtl/rs_decode_ctrl.sv
// Frame sequencer for the RS(255,239) decoder front end: beat forwarding, syndrome
// capture, optional key-equation solve and one registered result per frame.
module rs_decode_ctrl
  import rs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RS_BEAT_W-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [RS_BEAT_W-1:0] synd_data,
  output logic                 synd_valid,
  output logic                 synd_clear,
  input  logic [RS_SYND_W-1:0] synd_in,
  input  logic                 synd_done,
  output logic                 kes_start,
  output logic [RS_SYND_W-1:0] kes_synd,
  input  logic                 kes_done,
  input  logic                 kes_fail,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_err_free,
  output logic                 res_fail,
  output logic [1:0]           res_code
);

  state_e               state_q;
  logic [RS_TMO_W-1:0]  tmo_cnt_q;
  logic                 in_ready_q, synd_valid_q, synd_clear_q, kes_start_q;
  logic                 res_valid_q, res_err_free_q, res_fail_q, drain_q;
  logic [RS_BEAT_W-1:0] synd_data_q;
  logic [RS_SYND_W-1:0] kes_synd_q;
  res_code_e            res_code_q;

  logic xfer, beat0, frame_ok, frame_err, missing_last;

  assign xfer = in_valid & in_ready_q & (state_q == ST_LOAD);

  rs_frame_tracker u_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (state_q == ST_IDLE),
    .xfer_i         (xfer),
    .last_i         (in_last),
    .beat0_o        (beat0),
    .frame_ok_o     (frame_ok),
    .frame_err_o    (frame_err),
    .missing_last_o (missing_last)
  );

  // NOTE: every register here is updated with <= so all branches see pre-edge values;
  // the wide data registers are reset too because they drive module outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tmo_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      synd_valid_q   <= 1'b0;
      synd_clear_q   <= 1'b0;
      kes_start_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_err_free_q <= 1'b0;
      res_fail_q     <= 1'b0;
      drain_q        <= 1'b0;
      synd_data_q    <= '0;
      kes_synd_q     <= '0;
      res_code_q     <= RES_OK;
    end else begin
      synd_valid_q <= xfer;
      synd_clear_q <= xfer & beat0;
      kes_start_q  <= 1'b0;
      tmo_cnt_q    <= tmo_cnt_q + 1'b1;
      if (xfer) synd_data_q <= in_data;

      unique case (state_q)
        ST_IDLE: begin
          state_q    <= ST_LOAD;
          in_ready_q <= 1'b1;
          tmo_cnt_q  <= '0;
        end
        ST_LOAD: begin
          if (frame_ok) begin
            state_q    <= ST_WAIT_SYND;
            in_ready_q <= 1'b0;
            tmo_cnt_q  <= '0;
          end else if (frame_err) begin
            state_q        <= ST_RESULT;
            in_ready_q     <= 1'b0;
            tmo_cnt_q      <= '0;
            drain_q        <= missing_last;
            res_valid_q    <= 1'b1;
            res_code_q     <= RES_FRAMING;
            res_fail_q     <= 1'b1;
            res_err_free_q <= 1'b0;
          end
        end
        ST_WAIT_SYND: begin
          if (synd_done) begin
            kes_synd_q <= synd_in;
            state_q    <= ST_EVAL;
            tmo_cnt_q  <= '0;
          end else if (tmo_cnt_q == RS_TMO_W'(RS_SYND_TMO - 1)) begin
            state_q        <= ST_RESULT;
            tmo_cnt_q      <= '0;
            res_valid_q    <= 1'b1;
            res_code_q     <= RES_TIMEOUT;
            res_fail_q     <= 1'b1;
            res_err_free_q <= 1'b0;
          end
        end
        ST_EVAL: begin
          tmo_cnt_q <= '0;
          if (kes_synd_q == '0) begin
            state_q        <= ST_RESULT;
            res_valid_q    <= 1'b1;
            res_code_q     <= RES_OK;
            res_fail_q     <= 1'b0;
            res_err_free_q <= 1'b1;
          end else begin
            state_q     <= ST_SOLVE;
            kes_start_q <= 1'b1;
          end
        end
        ST_SOLVE: begin
          if (kes_done) begin
            state_q        <= ST_RESULT;
            tmo_cnt_q      <= '0;
            res_valid_q    <= 1'b1;
            res_code_q     <= kes_fail ? RES_KES_FAIL : RES_OK;
            res_fail_q     <= kes_fail;
            res_err_free_q <= 1'b0;
          end else if (tmo_cnt_q == RS_TMO_W'(RS_KES_TMO - 1)) begin
            state_q        <= ST_RESULT;
            tmo_cnt_q      <= '0;
            res_valid_q    <= 1'b1;
            res_code_q     <= RES_TIMEOUT;
            res_fail_q     <= 1'b1;
            res_err_free_q <= 1'b0;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            tmo_cnt_q   <= '0;
            if (drain_q) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          // Trailing beats of an overlong frame are swallowed, never forwarded.
          if (in_valid && in_last) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            drain_q    <= 1'b0;
            tmo_cnt_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign synd_data    = synd_data_q;
  assign synd_valid   = synd_valid_q;
  assign synd_clear   = synd_clear_q;
  assign kes_start    = kes_start_q;
  assign kes_synd     = kes_synd_q;
  assign res_valid    = res_valid_q;
  assign res_err_free = res_err_free_q;
  assign res_fail     = res_fail_q;
  assign res_code     = res_code_q;

endmodule

// File: tb/tb_rs_decode_ctrl.sv
// Directed bench for rs_decode_ctrl: a frame-level model checks forwarding, KES start
// and results every cycle; directed tests pin latencies and codes with literal values.
module tb_rs_decode_ctrl;
  import rs_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid, in_last, in_ready;
  logic [127:0] synd_data;
  logic         synd_valid, synd_clear;
  logic [127:0] synd_in;
  logic         synd_done;
  logic         kes_start;
  logic [127:0] kes_synd;
  logic         kes_done, kes_fail;
  logic         res_valid, res_ready, res_err_free, res_fail;
  logic [1:0]   res_code;

  always #5 clk = ~clk;

  rs_decode_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .synd_data    (synd_data),
    .synd_valid   (synd_valid),
    .synd_clear   (synd_clear),
    .synd_in      (synd_in),
    .synd_done    (synd_done),
    .kes_start    (kes_start),
    .kes_synd     (kes_synd),
    .kes_done     (kes_done),
    .kes_fail     (kes_fail),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_err_free (res_err_free),
    .res_fail     (res_fail),
    .res_code     (res_code)
  );

  typedef struct packed {
    logic [1:0] code;
    logic       err_free;
  } exp_t;

  int     n_cmp = 0;
  int     n_err = 0;
  exp_t   exp_q[$];
  logic [127:0] exp_kes_synd = '0;
  int     fwd_count = 0;
  int     kes_pulses = 0;
  int     res_seen = 0;

  // Frame-level model state.
  int           m_idx = 0;
  bit           m_drain = 0;
  bit           m_fwd = 0;
  bit           m_clear = 0;
  logic [127:0] m_data = '0;
  bit           m_hold = 0;
  bit           prev_ks = 0;
  logic [1:0]   snap_code;
  logic         snap_ef, snap_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: evaluates every cycle at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_idx = 0; m_drain = 0; m_fwd = 0; m_hold = 0; prev_ks = 0;
    end else begin
      if (synd_valid) fwd_count++;
      if (m_fwd) begin
        check("synd_valid", synd_valid, 1'b1);
        check("synd_data", synd_data, m_data);
        check("synd_clear", synd_clear, m_clear);
      end else begin
        check("synd_valid_idle", synd_valid, 1'b0);
        check("synd_clear_idle", synd_clear, 1'b0);
      end
      m_fwd = 0;
      if (in_valid && in_ready) begin
        if (m_drain) begin
          if (in_last) m_drain = 0;
        end else begin
          m_fwd   = 1;
          m_data  = in_data;
          m_clear = (m_idx == 0);
          m_idx++;
          if (in_last || m_idx == RS_BEATS) begin
            if (!in_last) m_drain = 1;
            m_idx = 0;
          end
        end
      end

      if (kes_start) begin
        kes_pulses++;
        check("kes_start_width", prev_ks, 1'b0);
        check("kes_synd", kes_synd, exp_kes_synd);
      end
      prev_ks = kes_start;

      if (res_valid) begin
        if (!m_hold) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", res_valid, 1'b0);
          end else begin
            check("res_code", res_code, exp_q[0].code);
            check("res_err_free", res_err_free, exp_q[0].err_free);
            check("res_fail", res_fail, exp_q[0].code != 2'b00);
          end
          snap_code = res_code; snap_ef = res_err_free; snap_fail = res_fail;
          m_hold = 1;
        end else begin
          check("res_code_stable", res_code, snap_code);
          check("res_err_free_stable", res_err_free, snap_ef);
          check("res_fail_stable", res_fail, snap_fail);
        end
        check("in_ready_in_result", in_ready, 1'b0);
        if (res_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          res_seen++;
          m_hold = 0;
        end
      end else if (m_hold) begin
        check("res_valid_dropped", res_valid, 1'b1);
        m_hold = 0;
      end
    end
  end

  task automatic expect_res(input logic [1:0] code, input logic ef);
    exp_t e;
    e.code = code;
    e.err_free = ef;
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 64) begin check("in_ready_timeout", in_ready, 1'b1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input bit zero_data, input int max_gap);
    logic [127:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = zero_data ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      if (k == RS_BEATS - 1) d[127:8] = '0;
      send_beat(d, k == last_at, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic pulse_synd(input int delay, input logic [127:0] v);
    repeat (delay) begin @(posedge clk); #1; end
    synd_done = 1'b1; synd_in = v;
    @(posedge clk); #1;
    synd_done = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (res_valid) break;
      if (n >= 400) begin check("res_valid_timeout", res_valid, 1'b1); break; end
    end
  endtask

  task automatic wait_kes(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (kes_start) break;
      if (n >= 16) begin check("kes_start_timeout", kes_start, 1'b1); break; end
    end
  endtask

  task automatic run_kes(input int delay, input logic fail);
    @(posedge clk); #1;
    repeat (delay - 1) begin @(posedge clk); #1; end
    kes_done = 1'b1; kes_fail = fail;
    @(posedge clk); #1;
    kes_done = 1'b0; kes_fail = 1'b0;
  endtask

  task automatic finish_res();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_synd_valid"}, synd_valid, 1'b0);
    check({tag, "_synd_clear"}, synd_clear, 1'b0);
    check({tag, "_kes_start"}, kes_start, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_synd_data"}, synd_data, 128'h0);
    check({tag, "_kes_synd"}, kes_synd, 128'h0);
    check({tag, "_res_err_free"}, res_err_free, 1'b0);
    check({tag, "_res_fail"}, res_fail, 1'b0);
    check({tag, "_res_code"}, res_code, 2'b00);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, f0, k0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    synd_in = '0; synd_done = 1'b0; kes_done = 1'b0; kes_fail = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: all-zero codeword, zero syndromes, KES skipped.
    expect_res(2'b00, 1'b1);
    k0 = kes_pulses;
    send_frame(16, 15, 1, 0);
    check("t1_in_ready_wait_synd", in_ready, 1'b0);
    pulse_synd(3, 128'h0);
    wait_res(n);
    check("t1_latency", n, 2);
    check("t1_code", res_code, 2'b00);
    check("t1_err_free", res_err_free, 1'b1);
    finish_res();
    check("t1_no_kes", kes_pulses - k0, 0);

    // 2: single nonzero syndrome, KES succeeds after 20 cycles.
    expect_res(2'b00, 1'b0);
    exp_kes_synd = 128'h01;
    k0 = kes_pulses;
    send_frame(16, 15, 0, 0);
    pulse_synd(5, 128'h01);
    wait_kes(n);
    check("t2_kes_latency", n, 2);
    check("t2_kes_synd", kes_synd, 128'h01);
    run_kes(20, 1'b0);
    wait_res(n);
    check("t2_res_latency", n, 1);
    check("t2_err_free", res_err_free, 1'b0);
    finish_res();
    check("t2_one_kes", kes_pulses - k0, 1);

    // 3: KES reports uncorrectable.
    expect_res(2'b01, 1'b0);
    send_frame(16, 15, 0, 0);
    pulse_synd(2, 128'h01);
    wait_kes(n);
    run_kes(20, 1'b1);
    wait_res(n);
    check("t3_code", res_code, 2'b01);
    check("t3_fail", res_fail, 1'b1);
    finish_res();

    // 4a: early in_last on beat 9.
    expect_res(2'b10, 1'b0);
    send_frame(10, 9, 0, 0);
    wait_res(n);
    check("t4_early_latency", n, 1);
    check("t4_early_code", res_code, 2'b10);
    finish_res();

    // 4b: 16 beats without in_last, then drain, then a clean frame.
    expect_res(2'b10, 1'b0);
    send_frame(16, -1, 0, 0);
    wait_res(n);
    check("t4_nolast_latency", n, 1);
    finish_res();
    f0 = fwd_count;
    send_frame(4, 3, 0, 0);
    expect_res(2'b00, 1'b1);
    send_frame(16, 15, 1, 0);
    pulse_synd(0, 128'h0);
    wait_res(n);
    check("t4_drain_not_forwarded", fwd_count - f0, 16);
    finish_res();

    // 5: syndrome engine never answers.
    expect_res(2'b11, 1'b0);
    send_frame(16, 15, 0, 0);
    wait_res(n);
    check("t5_synd_tmo_cycles", n - 1, RS_SYND_TMO);
    check("t5_code", res_code, 2'b11);
    finish_res();

    // 5b: reset while solving drops the frame; a late kes_done is ignored.
    exp_kes_synd = {64'hA5, 64'h0};
    send_frame(16, 15, 0, 0);
    pulse_synd(2, {64'hA5, 64'h0});
    wait_kes(n);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_solve");
    @(posedge clk); #1;
    kes_done = 1'b1; kes_fail = 1'b1;
    @(posedge clk); #1;
    kes_done = 1'b0; kes_fail = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t5b_no_result", res_valid, 1'b0);
    @(posedge clk); #1;
    expect_res(2'b00, 1'b1);
    send_frame(16, 15, 1, 0);
    pulse_synd(1, 128'h0);
    wait_res(n);
    finish_res();

    // 6: gapped input, result back-pressured for 10 cycles.
    expect_res(2'b00, 1'b0);
    exp_kes_synd = 128'hFF00;
    res_ready = 1'b0;
    f0 = fwd_count;
    send_frame(16, 15, 0, 3);
    pulse_synd(1, 128'hFF00);
    wait_kes(n);
    run_kes(7, 1'b0);
    wait_res(n);
    check("t6_res_latency", n, 1);
    check("t6_beats", fwd_count - f0, 16);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      synd_done = (i == 3); synd_in = 128'h5;
    end
    in_valid = 1'b0; synd_done = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("t6_held_valid", res_valid, 1'b1);
    finish_res();

    // Final clean frame after back-pressure.
    expect_res(2'b00, 1'b1);
    send_frame(16, 15, 1, 0);
    pulse_synd(0, 128'h0);
    wait_res(n);
    finish_res();
    repeat (3) @(posedge clk);

    check("results_outstanding", exp_q.size(), 0);
    check("results_seen", res_seen, 10);
    check("kes_total", kes_pulses, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
